alu_seq_ctrl: RTL and testbench

- Sequencing stage that sits directly upstream of the 2-bit ALU and feeds it.
- Accepts register-to-register instructions over a valid/ready handshake and reads operands from an internal 4-entry x 2-bit register file.
- Drives the ALU inputs (a, b, alu_op, functop), captures result/carry/borrow, then writes the result back and updates the flags.
- The ALU stays combinational and external; this block supplies all sequencing.

---
 rtl/alu_seq_ctrl_pkg.sv | 22 ++
 rtl/alu_regfile4x2.sv | 40 ++++
 rtl/alu_seq_ctrl.sv | 166 ++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_ctrl_pkg.sv
// Shared definitions for the ALU sequencing stage.
//   - ALU function codes driven on alu_funct
//   - FSM state encoding
//   - register-file geometry
package alu_seq_ctrl_pkg;

    localparam int REG_IDX_W = 2;
    localparam int DATA_W    = 2;
    localparam int NUM_REGS  = 1 << REG_IDX_W;

    localparam logic [4:0] FUNCT_ADD = 5'b01000;
    localparam logic [4:0] FUNCT_SUB = 5'b00100;
    localparam logic [4:0] FUNCT_AND = 5'b00000;
    localparam logic [4:0] FUNCT_OR  = 5'b11000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

endpackage

// File: rtl/alu_regfile4x2.sv
// 4-entry x 2-bit register file.
// Ports:
//   clk, rst          clock, async active-high reset (clears all entries)
//   we, waddr, wdata  single synchronous write port
//   raddr1 / rdata1   async read (ALU operand a)
//   raddr2 / rdata2   async read (ALU operand b)
//   raddr3 / rdata3   async read (debug)
module alu_regfile4x2
    import alu_seq_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] waddr,
    input  logic [DATA_W-1:0]    wdata,
    input  logic [REG_IDX_W-1:0] raddr1,
    output logic [DATA_W-1:0]    rdata1,
    input  logic [REG_IDX_W-1:0] raddr2,
    output logic [DATA_W-1:0]    rdata2,
    input  logic [REG_IDX_W-1:0] raddr3,
    output logic [DATA_W-1:0]    rdata3
);

    logic [DATA_W-1:0] mem [NUM_REGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata1 = mem[raddr1];
    assign rdata2 = mem[raddr2];
    assign rdata3 = mem[raddr3];

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencer feeding an external combinational 2-bit ALU.
// Accepts reg-to-reg instructions (in_valid/in_ready), reads operands from
// an internal 4x2 register file, presents them to the ALU for one cycle,
// captures result/carry/borrow, then writes back and updates flags.
// Ports:
//   clk, rst                       clock, async active-high reset
//   in_valid/in_ready, in_rd,
//   in_rs1, in_rs2, in_aluop,
//   in_funct                       instruction handshake and fields
//   ld_valid, ld_addr, ld_data     direct register load (IDLE only)
//   alu_a, alu_b, alu_op,
//   alu_funct                      ALU operand/control outputs
//   alu_result, alu_carry,
//   alu_borrow                     ALU outputs
//   done                           one-cycle retire pulse
//   carry_flag, borrow_flag        flags of last retired instruction
//   op_count                       retired-instruction count (wraps)
//   dbg_addr / dbg_data            async debug read of the register file
//
// state   | meaning
// IDLE    | waiting; loads and instruction accept happen here
// EXEC    | operands on ALU inputs; ALU outputs captured at end
// WB      | done=1; result written back, flags and count updated
module alu_seq_ctrl
    import alu_seq_ctrl_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [REG_IDX_W-1:0] in_rd,
    input  logic [REG_IDX_W-1:0] in_rs1,
    input  logic [REG_IDX_W-1:0] in_rs2,
    input  logic                 in_aluop,
    input  logic [4:0]           in_funct,
    input  logic                 ld_valid,
    input  logic [REG_IDX_W-1:0] ld_addr,
    input  logic [DATA_W-1:0]    ld_data,
    output logic [DATA_W-1:0]    alu_a,
    output logic [DATA_W-1:0]    alu_b,
    output logic                 alu_op,
    output logic [4:0]           alu_funct,
    input  logic [DATA_W-1:0]    alu_result,
    input  logic                 alu_carry,
    input  logic                 alu_borrow,
    output logic                 done,
    output logic                 carry_flag,
    output logic                 borrow_flag,
    output logic [CNT_W-1:0]     op_count,
    input  logic [REG_IDX_W-1:0] dbg_addr,
    output logic [DATA_W-1:0]    dbg_data
);

    state_t state_q, state_d;

    logic [DATA_W-1:0]    a_q, b_q, res_q;
    logic [REG_IDX_W-1:0] rd_q;
    logic                 op_q, carry_q, borrow_q;
    logic [4:0]           funct_q;

    logic                 accept;
    logic                 rf_we;
    logic [REG_IDX_W-1:0] rf_waddr;
    logic [DATA_W-1:0]    rf_wdata;
    logic [DATA_W-1:0]    rs1_data, rs2_data;

    alu_regfile4x2 u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (rf_we),
        .waddr  (rf_waddr),
        .wdata  (rf_wdata),
        .raddr1 (in_rs1),
        .rdata1 (rs1_data),
        .raddr2 (in_rs2),
        .rdata2 (rs2_data),
        .raddr3 (dbg_addr),
        .rdata3 (dbg_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Write port arbitration: writeback only happens in WB and loads only
    // in IDLE, so the two sources never collide.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        done     = 1'b0;
        accept   = 1'b0;
        rf_we    = 1'b0;
        rf_waddr = ld_addr;
        rf_wdata = ld_data;
        case (state_q)
            ST_IDLE: begin
                in_ready = !ld_valid;
                if (ld_valid) begin
                    rf_we = 1'b1;
                end else if (in_valid) begin
                    accept  = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_WB;
            end
            ST_WB: begin
                done     = 1'b1;
                rf_we    = 1'b1;
                rf_waddr = rd_q;
                rf_wdata = res_q;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            rd_q        <= '0;
            op_q        <= 1'b0;
            funct_q     <= '0;
            res_q       <= '0;
            carry_q     <= 1'b0;
            borrow_q    <= 1'b0;
            carry_flag  <= 1'b0;
            borrow_flag <= 1'b0;
            op_count    <= '0;
        end else begin
            if (accept) begin
                a_q     <= rs1_data;
                b_q     <= rs2_data;
                rd_q    <= in_rd;
                op_q    <= in_aluop;
                funct_q <= in_funct;
            end
            if (state_q == ST_EXEC) begin
                res_q    <= alu_result;
                carry_q  <= alu_carry;
                borrow_q <= alu_borrow;
            end
            if (state_q == ST_WB) begin
                carry_flag  <= carry_q;
                borrow_flag <= borrow_q;
                op_count    <= op_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_op    = op_q;
    assign alu_funct = funct_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
module tb_alu_seq_ctrl;
    import alu_seq_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready;
    logic [1:0] in_rd, in_rs1, in_rs2;
    logic       in_aluop;
    logic [4:0] in_funct;
    logic       ld_valid;
    logic [1:0] ld_addr, ld_data;
    logic [1:0] alu_a, alu_b;
    logic       alu_op;
    logic [4:0] alu_funct;
    logic [1:0] alu_result;
    logic       alu_carry, alu_borrow;
    logic       done, carry_flag, borrow_flag;
    logic [1:0] op_count;
    logic [1:0] dbg_addr, dbg_data;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int done_base;

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    alu_seq_ctrl #(.CNT_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_aluop   (in_aluop),
        .in_funct   (in_funct),
        .ld_valid   (ld_valid),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_funct  (alu_funct),
        .alu_result (alu_result),
        .alu_carry  (alu_carry),
        .alu_borrow (alu_borrow),
        .done       (done),
        .carry_flag (carry_flag),
        .borrow_flag(borrow_flag),
        .op_count   (op_count),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] idx, input logic [1:0] exp);
        dbg_addr = idx;
        #1;
        chk(tag, {30'd0, dbg_data}, {30'd0, exp});
    endtask

    task automatic load(input logic [1:0] addr, input logic [1:0] data);
        ld_valid = 1'b1;
        ld_addr  = addr;
        ld_data  = data;
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic issue(input logic [1:0] rd, input logic [1:0] rs1, input logic [1:0] rs2,
                         input logic op, input logic [4:0] f);
        in_valid = 1'b1;
        in_rd    = rd;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_aluop = op;
        in_funct = f;
    endtask

    task automatic stub(input logic [1:0] r, input logic c, input logic b);
        alu_result = r;
        alu_carry  = c;
        alu_borrow = b;
    endtask

    logic [1:0] exp_cnt [5];

    initial begin
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        rst = 1'b1;
        in_valid = 0; in_rd = 0; in_rs1 = 0; in_rs2 = 0; in_aluop = 0; in_funct = 0;
        ld_valid = 0; ld_addr = 0; ld_data = 0; dbg_addr = 0;
        stub(2'b00, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_op_count", {30'd0, op_count}, 32'd0);

        // 1: reset in the middle of EXEC aborts the instruction
        load(2'd0, 2'b01);
        issue(2'd0, 2'd0, 2'd0, 1'b1, FUNCT_ADD);
        stub(2'b11, 1'b1, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("t1_exec_a", {30'd0, alu_a}, 32'd1);
        done_base = done_cnt;
        rst = 1'b1;
        #2;
        chk("t1_done_in_rst", {31'd0, done}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        chk("t1_no_done", done_cnt - done_base, 32'd0);
        chk("t1_in_ready", {31'd0, in_ready}, 32'd1);
        chk("t1_op_count", {30'd0, op_count}, 32'd0);
        chk("t1_carry", {31'd0, carry_flag}, 32'd0);
        tick();
        chk_reg("t1_r0", 2'd0, 2'b00);
        chk_reg("t1_r1", 2'd1, 2'b00);
        chk_reg("t1_r2", 2'd2, 2'b00);
        chk_reg("t1_r3", 2'd3, 2'b00);

        // 2: basic ADD, stub returns result=10 carry=1
        load(2'd0, 2'b01);
        load(2'd1, 2'b11);
        issue(2'd2, 2'd0, 2'd1, 1'b1, FUNCT_ADD);
        stub(2'b10, 1'b1, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("t2_alu_a", {30'd0, alu_a}, 32'd1);
        chk("t2_alu_b", {30'd0, alu_b}, 32'd3);
        chk("t2_alu_op", {31'd0, alu_op}, 32'd1);
        chk("t2_alu_funct", {27'd0, alu_funct}, {27'd0, FUNCT_ADD});
        chk("t2_exec_done", {31'd0, done}, 32'd0);
        chk("t2_exec_ready", {31'd0, in_ready}, 32'd0);
        tick();
        chk("t2_wb_done", {31'd0, done}, 32'd1);
        tick();
        chk("t2_idle_done", {31'd0, done}, 32'd0);
        chk("t2_carry", {31'd0, carry_flag}, 32'd1);
        chk("t2_borrow", {31'd0, borrow_flag}, 32'd0);
        chk("t2_op_count", {30'd0, op_count}, 32'd1);
        chk_reg("t2_r2", 2'd2, 2'b10);

        // 3: load and instruction in the same cycle; load wins
        ld_valid = 1'b1; ld_addr = 2'd3; ld_data = 2'b10;
        issue(2'd1, 2'd3, 2'd3, 1'b0, FUNCT_AND);
        #1;
        chk("t3_ready_low", {31'd0, in_ready}, 32'd0);
        tick();
        ld_valid = 1'b0;
        #1;
        chk("t3_ready_high", {31'd0, in_ready}, 32'd1);
        chk_reg("t3_r3_loaded", 2'd3, 2'b10);
        stub(2'b10, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("t3_alu_a", {30'd0, alu_a}, 32'd2);
        chk("t3_alu_b", {30'd0, alu_b}, 32'd2);
        tick();
        tick();
        chk_reg("t3_r1", 2'd1, 2'b10);
        chk("t3_carry", {31'd0, carry_flag}, 32'd0);
        chk("t3_op_count", {30'd0, op_count}, 32'd2);

        // 4: back-to-back dependent ops with in_valid held high
        // R0=01, R1=10, R3=10. OR R3 <- R0|R3 = 11, then AND R0 <- R3&R1 = 10
        issue(2'd3, 2'd0, 2'd3, 1'b0, FUNCT_OR);
        stub(2'b11, 1'b0, 1'b0);
        tick();
        issue(2'd0, 2'd3, 2'd1, 1'b0, FUNCT_AND);
        chk("t4_op1_a", {30'd0, alu_a}, 32'd1);
        chk("t4_op1_b", {30'd0, alu_b}, 32'd2);
        chk("t4_op1_funct", {27'd0, alu_funct}, {27'd0, FUNCT_OR});
        tick();
        chk("t4_wb_ready", {31'd0, in_ready}, 32'd0);
        tick();
        chk("t4_idle_ready", {31'd0, in_ready}, 32'd1);
        chk_reg("t4_r3_new", 2'd3, 2'b11);
        stub(2'b10, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("t4_op2_a", {30'd0, alu_a}, 32'd3);
        chk("t4_op2_b", {30'd0, alu_b}, 32'd2);
        chk("t4_op2_funct", {27'd0, alu_funct}, {27'd0, FUNCT_AND});
        tick();
        tick();
        chk_reg("t4_r0", 2'd0, 2'b10);
        chk("t4_borrow", {31'd0, borrow_flag}, 32'd1);
        chk("t4_op_count_wrap", {30'd0, op_count}, 32'd0);

        // 5: loads during EXEC/WB are dropped
        // R0=10: ADD R1 <- R0+R0, stub result 01
        issue(2'd1, 2'd0, 2'd0, 1'b1, FUNCT_ADD);
        stub(2'b01, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        ld_valid = 1'b1; ld_addr = 2'd2; ld_data = 2'b11;
        #1;
        chk("t5_exec_ready", {31'd0, in_ready}, 32'd0);
        tick();
        ld_addr = 2'd1; ld_data = 2'b11;
        chk("t5_wb_done", {31'd0, done}, 32'd1);
        tick();
        ld_valid = 1'b0;
        chk_reg("t5_r2_kept", 2'd2, 2'b10);
        chk_reg("t5_r1_result", 2'd1, 2'b01);
        chk("t5_borrow_cleared", {31'd0, borrow_flag}, 32'd0);

        // 6: count wrap with CNT_W=2 from a fresh reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        stub(2'b01, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            issue(2'(i), 2'd0, 2'd1, 1'b0, FUNCT_SUB);
            tick();
            in_valid = 1'b0;
            chk("t6_exec_ready", {31'd0, in_ready}, 32'd0);
            tick();
            chk("t6_wb_ready", {31'd0, in_ready}, 32'd0);
            chk("t6_wb_done", {31'd0, done}, 32'd1);
            tick();
            chk("t6_op_count", {30'd0, op_count}, {30'd0, exp_cnt[i]});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
